// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage between IF/ID and ID/EX.
// Decodes the immediate, format code and illegal flag from a raw 32-bit
// instruction before the pipeline register. The instruction and a tag are
// carried alongside the decode on a valid/ready handshake. An optional
// second register (skid) lets in_ready be a pure flop output.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_CSRI  = 3'd6;
  localparam logic [2:0] FMT_SHAMT = 3'd7;

  // One stored entry: {imm, fmt, illegal, instr, tag}
  localparam int ENT_W = XLEN + 3 + 1 + 32 + TAG_W;

  // Sign-extend a 32-bit immediate to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  // Zero-extend a shift amount / CSR immediate to XLEN.
  function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
    return XLEN'(v);
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [5:0]      shamt_native;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [ENT_W-1:0] dec_ent;

  assign opcode       = in_instr[6:0];
  assign funct3       = in_instr[14:12];
  assign is_shift     = (funct3 == 3'b001) || (funct3 == 3'b101);
  // RV64 OP-IMM shifts take bit 25 as shamt[5]; funct7 bits above never leak in.
  assign shamt_native = IS64 ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  // Immediate decode; every listed opcode ends in 2'b11, so a non-32-bit
  // encoding falls to the default illegal arm.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    unique case (opcode)
      OPC_OP_IMM: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          dec_imm = zext6(shamt_native);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
      end
      OPC_OP_IMM_32: begin
        if (!IS64) begin
          dec_illegal = 1'b1;
        end else if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          dec_imm = zext6({1'b0, in_instr[24:20]});
        end else begin
          dec_fmt = FMT_I;
          dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        end
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0});
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0});
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = sext32({in_instr[31:12], 12'b0});
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          dec_fmt = FMT_CSRI;
          dec_imm = zext6({1'b0, in_instr[19:15]});
        end
      end
      OPC_OP, OPC_MISC_MEM: begin
        dec_fmt = FMT_NONE;
      end
      OPC_OP_32: begin
        dec_illegal = !IS64;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_ent = {dec_imm, dec_fmt, dec_illegal, in_instr, in_tag};

  logic             vld_p1;
  logic [ENT_W-1:0] main_ent_p1;
  logic             push;
  logic             pop;

  assign pop = vld_p1 && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_vld_p1;
      logic [ENT_W-1:0] skid_ent_p1;

      assign in_ready = !skid_vld_p1;
      assign push     = in_valid && !skid_vld_p1;

      // ---- stage p1: main/skid occupancy and main register ----
      // Main refills from skid first so ordering holds; skid only fills while
      // main is full and stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1      <= 1'b0;
          skid_vld_p1 <= 1'b0;
          main_ent_p1 <= '0;
        end else if (flush) begin
          vld_p1      <= 1'b0;
          skid_vld_p1 <= 1'b0;
        end else if (!vld_p1 || pop) begin
          if (skid_vld_p1) begin
            vld_p1      <= 1'b1;
            main_ent_p1 <= skid_ent_p1;
            skid_vld_p1 <= 1'b0;
          end else begin
            vld_p1 <= push;
            if (push) main_ent_p1 <= dec_ent;
          end
        end else if (push) begin
          skid_vld_p1 <= 1'b1;
        end
      end

      // Skid payload; its valid bit alone decides whether it is meaningful.
      always_ff @(posedge clk) begin
        if (push && vld_p1 && !pop) skid_ent_p1 <= dec_ent;
      end
    end else begin : g_noskid
      assign in_ready = !vld_p1 || out_ready;
      assign push     = in_valid && in_ready;

      // ---- stage p1: single pipeline register ----
      // Advances whenever empty or being popped.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1      <= 1'b0;
          main_ent_p1 <= '0;
        end else if (flush) begin
          vld_p1 <= 1'b0;
        end else if (in_ready) begin
          vld_p1 <= push;
          if (push) main_ent_p1 <= dec_ent;
        end
      end
    end
  endgenerate

  assign out_valid = vld_p1;
  assign {out_imm, out_fmt, out_illegal, out_instr, out_tag} = main_ent_p1;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: three instances (XLEN32/SKID1,
// XLEN64/SKID1, XLEN32/SKID0) share the input stimulus.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm, a_out_instr, a_out_tag;
  logic [2:0]  a_out_fmt;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [31:0] b_out_instr, b_out_tag;
  logic [2:0]  b_out_fmt;
  logic        c_in_ready, c_out_valid, c_out_illegal;
  logic [31:0] c_out_imm, c_out_instr, c_out_tag;
  logic [2:0]  c_out_fmt;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
    .out_instr(a_out_instr), .out_tag(a_out_tag));

  imm_decode_stage #(.XLEN(64), .TAG_W(32), .SKID(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
    .out_instr(b_out_instr), .out_tag(b_out_tag));

  imm_decode_stage #(.XLEN(32), .TAG_W(32), .SKID(0)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_imm(c_out_imm), .out_fmt(c_out_fmt), .out_illegal(c_out_illegal),
    .out_instr(c_out_instr), .out_tag(c_out_tag));

  // Selected view (SKID1 instance a or SKID0 instance c) for the backpressure run
  logic        use_c;
  logic        s_ready, s_valid;
  logic [31:0] s_tag, s_imm;
  always_comb begin
    s_ready = use_c ? c_in_ready  : a_in_ready;
    s_valid = use_c ? c_out_valid : a_out_valid;
    s_tag   = use_c ? c_out_tag   : a_out_tag;
    s_imm   = use_c ? c_out_imm   : a_out_imm;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
    tick();
  endtask

  // Four back-to-back inputs, downstream stalled for the first three cycles.
  task automatic run_bp(input bit sel_c, input int exp_acc);
    int idx, pops, first, last;
    bit acc;
    idx = 0; pops = 0; first = -1; last = -1;
    use_c = sel_c;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid  = (idx < 4);
      in_instr  = {12'(idx), 20'h00013};
      in_tag    = 32'hB000 + 32'(idx);
      out_ready = (cyc >= 3);
      #1;
      if (cyc == 2) begin
        chk($sformatf("bp%0d_accepted", sel_c), 64'(idx), 64'(exp_acc));
        chk($sformatf("bp%0d_in_ready_low", sel_c), {63'd0, s_ready}, 64'd0);
        chk($sformatf("bp%0d_stalled_tag", sel_c), {32'd0, s_tag}, 64'hB000);
      end
      if (s_valid && out_ready) begin
        chk($sformatf("bp%0d_pop%0d_tag", sel_c, pops), {32'd0, s_tag}, 64'hB000 + 64'(pops));
        chk($sformatf("bp%0d_pop%0d_imm", sel_c, pops), {32'd0, s_imm}, 64'(pops));
        if (first < 0) first = cyc;
        last = cyc;
        pops++;
      end
      acc = in_valid && s_ready;
      tick();
      if (acc) idx++;
    end
    chk($sformatf("bp%0d_total_pops", sel_c), 64'(pops), 64'd4);
    chk($sformatf("bp%0d_pop_span", sel_c), 64'(last - first), 64'd3);
    chk($sformatf("bp%0d_all_accepted", sel_c), 64'(idx), 64'd4);
    in_valid = 1'b0;
  endtask

  localparam int NV = 14;
  logic [31:0] v_instr [NV];
  logic [31:0] ea_imm  [NV];
  logic [2:0]  ea_fmt  [NV];
  logic        ea_ill  [NV];
  logic [63:0] eb_imm  [NV];
  logic [2:0]  eb_fmt  [NV];
  logic        eb_ill  [NV];

  initial begin
    v_instr = '{32'hFFF00093, 32'hFE112E23, 32'hFF9FF06F, 32'hFE000EE3, 32'h800000B7,
                32'h4010D093, 32'h300FD073, 32'h00000000, 32'h03F09093, 32'h03F0909B,
                32'h003100B3, 32'h0000003B, 32'h00001073, 32'h00000092};
    ea_imm  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h80000000,
                32'h1, 32'h1F, 32'h0, 32'h1F, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ea_fmt  = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd4, 3'd7, 3'd6, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    ea_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    eb_imm  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h1, 64'h1F, 64'h0,
                64'h3F, 64'h1F, 64'h0, 64'h0, 64'h0, 64'h0};
    eb_fmt  = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd4, 3'd7, 3'd6, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
    eb_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    use_c     = 1'b0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_tag    = 32'h0;
    out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_a_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_a_imm",   {32'd0, a_out_imm}, 64'd0);
    chk("rst_a_fmt",   {61'd0, a_out_fmt}, 64'd0);
    chk("rst_a_ill",   {63'd0, a_out_illegal}, 64'd0);
    chk("rst_a_instr", {32'd0, a_out_instr}, 64'd0);
    chk("rst_a_tag",   {32'd0, a_out_tag}, 64'd0);
    chk("rst_b_valid", {63'd0, b_out_valid}, 64'd0);
    chk("rst_b_imm",   b_out_imm, 64'd0);
    chk("rst_c_valid", {63'd0, c_out_valid}, 64'd0);
    #10;
    rst = 1'b0;
    tick();
    chk("post_rst_a_ready", {63'd0, a_in_ready}, 64'd1);
    chk("post_rst_b_ready", {63'd0, b_in_ready}, 64'd1);
    chk("post_rst_c_ready", {63'd0, c_in_ready}, 64'd1);

    // Decode stream, one instruction per cycle, downstream always ready
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = v_instr[i];
      in_tag   = 32'h1000 + 32'(i);
      tick();
      chk($sformatf("dec%0d_a_valid", i), {63'd0, a_out_valid}, 64'd1);
      chk($sformatf("dec%0d_a_imm", i),   {32'd0, a_out_imm}, {32'd0, ea_imm[i]});
      chk($sformatf("dec%0d_a_fmt", i),   {61'd0, a_out_fmt}, {61'd0, ea_fmt[i]});
      chk($sformatf("dec%0d_a_ill", i),   {63'd0, a_out_illegal}, {63'd0, ea_ill[i]});
      chk($sformatf("dec%0d_a_tag", i),   {32'd0, a_out_tag}, 64'h1000 + 64'(i));
      chk($sformatf("dec%0d_a_instr", i), {32'd0, a_out_instr}, {32'd0, v_instr[i]});
      chk($sformatf("dec%0d_b_valid", i), {63'd0, b_out_valid}, 64'd1);
      chk($sformatf("dec%0d_b_imm", i),   b_out_imm, eb_imm[i]);
      chk($sformatf("dec%0d_b_fmt", i),   {61'd0, b_out_fmt}, {61'd0, eb_fmt[i]});
      chk($sformatf("dec%0d_b_ill", i),   {63'd0, b_out_illegal}, {63'd0, eb_ill[i]});
      chk($sformatf("dec%0d_b_tag", i),   {32'd0, b_out_tag}, 64'h1000 + 64'(i));
      chk($sformatf("dec%0d_b_instr", i), {32'd0, b_out_instr}, {32'd0, v_instr[i]});
      chk($sformatf("dec%0d_c_valid", i), {63'd0, c_out_valid}, 64'd1);
      chk($sformatf("dec%0d_c_imm", i),   {32'd0, c_out_imm}, {32'd0, ea_imm[i]});
      chk($sformatf("dec%0d_c_fmt", i),   {61'd0, c_out_fmt}, {61'd0, ea_fmt[i]});
      chk($sformatf("dec%0d_c_ill", i),   {63'd0, c_out_illegal}, {63'd0, ea_ill[i]});
      chk($sformatf("dec%0d_c_tag", i),   {32'd0, c_out_tag}, 64'h1000 + 64'(i));
      chk($sformatf("dec%0d_c_instr", i), {32'd0, c_out_instr}, {32'd0, v_instr[i]});
    end
    in_valid = 1'b0;
    tick();
    chk("dec_drain_a_valid", {63'd0, a_out_valid}, 64'd0);
    chk("dec_drain_b_valid", {63'd0, b_out_valid}, 64'd0);
    chk("dec_drain_c_valid", {63'd0, c_out_valid}, 64'd0);

    // Backpressure, skid buffer then single register
    do_reset();
    run_bp(1'b0, 2);
    do_reset();
    run_bp(1'b1, 1);

    // Flush with both entries of the skid instance full
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100013;
    in_tag    = 32'hF0;
    tick();
    in_instr  = 32'h00200013;
    in_tag    = 32'hF1;
    tick();
    chk("fl_full_a_ready", {63'd0, a_in_ready}, 64'd0);
    chk("fl_full_a_valid", {63'd0, a_out_valid}, 64'd1);
    flush    = 1'b1;
    in_instr = 32'h00300013;
    in_tag   = 32'hF2;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_a_valid", {63'd0, a_out_valid}, 64'd0);
    chk("fl_a_ready", {63'd0, a_in_ready}, 64'd1);
    chk("fl_c_valid", {63'd0, c_out_valid}, 64'd0);
    out_ready = 1'b1;
    tick();
    chk("fl_after_a_valid", {63'd0, a_out_valid}, 64'd0);
    chk("fl_after_c_valid", {63'd0, c_out_valid}, 64'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00400013;
    in_tag   = 32'hF3;
    tick();
    flush    = 1'b0;
    chk("fl_drop_a_valid", {63'd0, a_out_valid}, 64'd0);
    chk("fl_drop_c_valid", {63'd0, c_out_valid}, 64'd0);
    in_instr = 32'h00500013;
    in_tag   = 32'hF4;
    tick();
    in_valid = 1'b0;
    chk("fl_next_a_valid", {63'd0, a_out_valid}, 64'd1);
    chk("fl_next_a_tag",   {32'd0, a_out_tag}, 64'hF4);
    chk("fl_next_a_imm",   {32'd0, a_out_imm}, 64'd5);
    chk("fl_next_c_tag",   {32'd0, c_out_tag}, 64'hF4);
    tick();
    chk("fl_end_a_valid", {63'd0, a_out_valid}, 64'd0);

    // Asynchronous reset with entries pending
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    in_tag    = 32'hA0;
    tick();
    in_tag    = 32'hA1;
    tick();
    in_valid  = 1'b0;
    chk("mr_pre_a_valid", {63'd0, a_out_valid}, 64'd1);
    chk("mr_pre_a_imm",   {32'd0, a_out_imm}, 64'hFFFFFFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_a_valid", {63'd0, a_out_valid}, 64'd0);
    chk("mr_a_imm",   {32'd0, a_out_imm}, 64'd0);
    chk("mr_a_fmt",   {61'd0, a_out_fmt}, 64'd0);
    chk("mr_a_tag",   {32'd0, a_out_tag}, 64'd0);
    chk("mr_a_instr", {32'd0, a_out_instr}, 64'd0);
    chk("mr_a_ready", {63'd0, a_in_ready}, 64'd1);
    chk("mr_b_imm",   b_out_imm, 64'd0);
    chk("mr_c_valid", {63'd0, c_out_valid}, 64'd0);
    tick();
    rst       = 1'b0;
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00700013;
    in_tag    = 32'hA2;
    tick();
    in_valid  = 1'b0;
    chk("mr_resume_a_valid", {63'd0, a_out_valid}, 64'd1);
    chk("mr_resume_a_tag",   {32'd0, a_out_tag}, 64'hA2);
    chk("mr_resume_a_imm",   {32'd0, a_out_imm}, 64'd7);
    tick();
    chk("mr_end_a_valid", {63'd0, a_out_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
